// File: rtl/pwm_output_stage_pkg.sv
// Shared constants and helper types for the PWM output stage.
// Both the timebase and the top-level pin mux import this package.
package pwm_output_stage_pkg;

   localparam int PWM_RES  = 256;
   localparam int DUTY_W   = 8;
   localparam int NUM_PINS = 16;

   localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
   localparam logic [DUTY_W-1:0] CNT_LAST  = 8'(PWM_RES - 1);

   typedef enum logic [1:0] {
      PIN_LOW  = 2'd0,
      PIN_HIGH = 2'd1,
      PIN_PWM  = 2'd2
   } pin_mode_e;

   // Output enable dominates; the PWM select only matters for enabled pins.
   function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
      pin_mode_e m;
      if (!en_out) begin
         m = PIN_LOW;
      end else if (!en_pwm) begin
         m = PIN_HIGH;
      end else begin
         m = PIN_PWM;
      end
      return m;
   endfunction

endpackage

// File: rtl/pwm_output_stage_timebase.sv
// Prescaler and 8-bit PWM step counter; flags the period wrap and
// produces a registered one-clock period_start pulse after it.
module pwm_output_stage_timebase
   import pwm_output_stage_pkg::*;
#(
   parameter int CLK_DIV = 13,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [DUTY_W-1:0] pwm_cnt,
   output logic              wrap,
   output logic              period_start
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0]  prescale_cnt_q, prescale_cnt_d;
   logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic              period_start_q, period_start_d;
   logic              tick;

   always_comb begin
      tick           = (prescale_cnt_q == DIV_LAST);
      wrap           = tick && (pwm_cnt_q == CNT_LAST);
      prescale_cnt_d = prescale_cnt_q + CNT_W'(1);
      pwm_cnt_d      = pwm_cnt_q;
      period_start_d = wrap;
      if (tick) begin
         prescale_cnt_d = '0;
         // 8-bit add wraps 255 -> 0 naturally.
         pwm_cnt_d      = pwm_cnt_q + DUTY_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_cnt_q <= '0;
         pwm_cnt_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         prescale_cnt_q <= prescale_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_cnt      = pwm_cnt_q;
   assign period_start = period_start_q;

endmodule

// File: rtl/pwm_output_stage.sv
// 16-pin output stage: per-pin low / high / shared PWM, with the duty
// cycle shadowed so new values only take effect at a period boundary.
module pwm_output_stage
   import pwm_output_stage_pkg::*;
#(
   parameter int CLK_DIV = 13,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          en_reg_out_7_0,
   input  logic [7:0]          en_reg_out_15_8,
   input  logic [7:0]          en_reg_pwm_7_0,
   input  logic [7:0]          en_reg_pwm_15_8,
   input  logic [DUTY_W-1:0]   pwm_duty_cycle,
   output logic [NUM_PINS-1:0] out,
   output logic                period_start
);

   logic [DUTY_W-1:0]   pwm_cnt;
   logic                wrap;
   logic [DUTY_W-1:0]   duty_shadow_q, duty_shadow_d;
   logic [NUM_PINS-1:0] out_q, out_d;
   logic [NUM_PINS-1:0] en_out, en_pwm;
   logic                pwm_raw;

   pwm_output_stage_timebase #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_cnt      (pwm_cnt),
      .wrap         (wrap),
      .period_start (period_start)
   );

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   always_comb begin
      duty_shadow_d = duty_shadow_q;
      if (wrap) begin
         duty_shadow_d = pwm_duty_cycle;
      end
      // Full-scale duty is forced high so there is no single low step.
      if (duty_shadow_q == DUTY_FULL) begin
         pwm_raw = 1'b1;
      end else begin
         pwm_raw = (pwm_cnt < duty_shadow_q);
      end
   end

   // Enables are deliberately not shadowed: they act on the next clock.
   always_comb begin
      out_d = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         case (pin_mode(en_out[i], en_pwm[i]))
            PIN_HIGH: out_d[i] = 1'b1;
            PIN_PWM:  out_d[i] = pwm_raw;
            default:  out_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_shadow_q <= '0;
         out_q         <= '0;
      end else begin
         duty_shadow_q <= duty_shadow_d;
         out_q         <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: per-cycle reference model plus
// directed duty, enable, high-time and mid-period reset scenarios.
module tb_pwm_output_stage;

   localparam int CLK_DIV = 13;
   localparam int PWM_RES = 256;
   localparam int PERIOD  = PWM_RES * CLK_DIV;

   // clock / reset
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   pwm_output_stage #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   // scoreboard state
   int          n_cmp  = 0;
   int          n_bad  = 0;
   logic [16:0] exp_q[$];
   int          m_t;        // clock edges since reset release
   logic [7:0]  m_shadow;   // duty in force for the current model period
   int          hi_cnt;
   bit          meas_on = 1'b0;
   int          first_ps = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the output after an edge reflects the step count and duty
   // in force just before that edge, and the enables present at it.
   function automatic logic [15:0] model_out(input int t);
      int          stp = (t / CLK_DIV) % PWM_RES;
      logic [15:0] eo  = {en_reg_out_15_8, en_reg_out_7_0};
      logic [15:0] ep  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      logic        hi;
      logic [15:0] r;
      if (m_shadow == 8'hFF) hi = 1'b1;
      else                   hi = (stp < int'(m_shadow));
      for (int i = 0; i < 16; i++) begin
         if (!eo[i])      r[i] = 1'b0;
         else if (!ep[i]) r[i] = 1'b1;
         else             r[i] = hi;
      end
      return r;
   endfunction

   // driver: called at a negedge, checks every following edge
   task automatic run(input int n);
      logic [16:0] e;
      bit          boundary;
      for (int i = 0; i < n; i++) begin
         boundary = (((m_t + 1) % PERIOD) == 0);
         exp_q.push_back({model_out(m_t), boundary});
         if (boundary) m_shadow = pwm_duty_cycle;
         @(posedge clk);
         #1;
         m_t++;
         e = exp_q.pop_front();
         check("out", {16'h0, out}, {16'h0, e[16:1]});
         check("period_start", {31'h0, period_start}, {31'h0, e[0]});
         if (meas_on && out[0] === 1'b1) hi_cnt++;
         if (period_start === 1'b1 && first_ps < 0) first_ps = m_t;
         @(negedge clk);
      end
   endtask

   task automatic run_to(input int target);
      run(target - m_t);
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
   endtask

   // Load a duty at the next boundary, then count pin-0 highs for one period.
   task automatic measure_duty(input logic [7:0] d, input int exp_hi, input string tag);
      pwm_duty_cycle = d;
      run_to(((m_t / PERIOD) + 1) * PERIOD);
      hi_cnt  = 0;
      meas_on = 1'b1;
      run(PERIOD);
      meas_on = 1'b0;
      check(tag, hi_cnt, exp_hi);
   endtask

   initial begin
      rst_n          = 1'b0;
      set_en(16'h0000, 16'h0000);
      pwm_duty_cycle = 8'h00;
      m_shadow       = 8'h00;
      m_t            = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", {16'h0, out}, 32'h0);
      check("reset_period_start", {31'h0, period_start}, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;

      // static-high pins only on the low byte
      set_en(16'h00FF, 16'h0000);
      pwm_duty_cycle = 8'h80;
      run(1);
      check("static_low_byte", {16'h0, out}, 32'h0000_00FF);
      run(20);

      // all pins PWM; first period runs with a zero shadow
      set_en(16'hFFFF, 16'hFFFF);
      run_to(PERIOD);
      check("first_period_start_edge", first_ps, PERIOD);

      measure_duty(8'h80, 128 * CLK_DIV, "hi_time_duty_80");
      measure_duty(8'h00, 0, "hi_time_duty_00");
      measure_duty(8'hFF, PERIOD, "hi_time_duty_ff");

      // duty change mid-period only applies from the next period
      pwm_duty_cycle = 8'h40;
      run_to(((m_t / PERIOD) + 1) * PERIOD);
      hi_cnt  = 0;
      meas_on = 1'b1;
      run(100 * CLK_DIV);
      pwm_duty_cycle = 8'hC0;
      run(PERIOD - 100 * CLK_DIV);
      check("hi_time_before_change", hi_cnt, 64 * CLK_DIV);
      hi_cnt = 0;
      run(PERIOD);
      meas_on = 1'b0;
      check("hi_time_after_change", hi_cnt, 192 * CLK_DIV);

      // randomized enables, duty and segment lengths
      for (int r = 0; r < 6; r++) begin
         set_en(16'($urandom), 16'($urandom));
         pwm_duty_cycle = 8'($urandom);
         run($urandom_range(200, 1500));
      end

      // mid-period reset at step 50 with duty 0x80
      set_en(16'hFFFF, 16'hFFFF);
      measure_duty(8'h80, 128 * CLK_DIV, "hi_time_pre_reset");
      run(50 * CLK_DIV);
      rst_n = 1'b0;
      #1;
      check("async_reset_out", {16'h0, out}, 32'h0);
      check("async_reset_period_start", {31'h0, period_start}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("held_reset_out", {16'h0, out}, 32'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      m_t      = 0;
      m_shadow = 8'h00;
      hi_cnt   = 0;
      meas_on  = 1'b1;
      run(PERIOD);
      check("hi_time_post_reset_first", hi_cnt, 0);
      hi_cnt = 0;
      run(PERIOD);
      meas_on = 1'b0;
      check("hi_time_post_reset_second", hi_cnt, 128 * CLK_DIV);

      // static-high pins mixed with PWM pins after everything above
      set_en(16'hF0F0, 16'h3030);
      run(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
